// File: rtl/truco_pkg.sv
// Shared encodings for the Truco round tracker: hand result codes, FSM states,
// the stake ladder and team encoding.
package truco_pkg;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_A    = 2'b01;
    localparam logic [1:0] RES_B    = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    localparam logic TEAM_A = 1'b0;
    localparam logic TEAM_B = 1'b1;

    localparam logic [3:0] STAKE_1  = 4'd1;
    localparam logic [3:0] STAKE_3  = 4'd3;
    localparam logic [3:0] STAKE_6  = 4'd6;
    localparam logic [3:0] STAKE_9  = 4'd9;
    localparam logic [3:0] STAKE_12 = 4'd12;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_ROUND_END = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    // One step up the truco ladder; the top rung is sticky.
    function automatic logic [3:0] next_stake(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            STAKE_1: r = STAKE_3;
            STAKE_3: r = STAKE_6;
            STAKE_6: r = STAKE_9;
            default: r = STAKE_12;
        endcase
        return r;
    endfunction

    function automatic logic res_team(input logic [1:0] r);
        return (r == RES_B) ? TEAM_B : TEAM_A;
    endfunction

endpackage

// File: rtl/truco_round_resolver.sv
// Combinational best-of-3 tie rules: given the hands played so far and the
// index of the hand being played now, says whether the round is decided and by whom.
module truco_round_resolver
    import truco_pkg::*;
(
    input  logic [1:0] h0,
    input  logic [1:0] h1,
    input  logic [1:0] h2,
    input  logic [1:0] hand_idx,
    input  logic       mao_team,
    output logic       decided,
    output logic       winner
);

    always_comb begin
        decided = 1'b0;
        winner  = TEAM_A;
        case (hand_idx)
            2'd1: begin
                if (h0 == RES_TIE && h1 != RES_TIE) begin
                    decided = 1'b1;
                    winner  = res_team(h1);
                end else if (h0 != RES_TIE && (h1 == h0 || h1 == RES_TIE)) begin
                    decided = 1'b1;
                    winner  = res_team(h0);
                end
            end
            2'd2: begin
                // The third hand always closes the round; ties fall back to hand 0, then mao.
                decided = 1'b1;
                if (h2 != RES_TIE)      winner = res_team(h2);
                else if (h0 != RES_TIE) winner = res_team(h0);
                else                    winner = mao_team;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/truco_round_tracker.sv
// Truco round/score tracker: resolves best-of-3 rounds, tracks the stake ladder,
// accumulates saturating team scores. Optional macro MAO_DE_ONZE_EN enables the mao-de-onze rule.
module truco_round_tracker
    import truco_pkg::*;
#(
    parameter int WIN_SCORE = 12,
    parameter int SCORE_W   = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               new_game,
    input  logic               hand_valid,
    input  logic [1:0]         hand_result,
    input  logic               mao_team,
    input  logic               truco_req,
    input  logic               fold_valid,
    input  logic               fold_team,
    output logic [1:0]         hand_idx,
    output logic [3:0]         round_value,
    output logic               round_done,
    output logic               round_winner,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               game_over,
    output logic               game_winner
);

    localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] WIN_M1 = SCORE_W'(WIN_SCORE - 1);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [3:0]         v);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(v);
        if (sum >= (SCORE_W+1)'(WIN_SCORE)) return WIN;
        return sum[SCORE_W-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         hand_idx_q, hand_idx_d;
    logic [3:0]         round_value_q, round_value_d;
    logic [1:0]         h0_q, h0_d;
    logic [1:0]         h1_q, h1_d;
    logic               round_done_q, round_done_d;
    logic               round_winner_q, round_winner_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic               game_over_q, game_over_d;
    logic               game_winner_q, game_winner_d;

    logic       mao_onze;
    logic [3:0] stake_raised;
    logic       hand_legal;
    logic       res_decided;
    logic       res_winner;
    logic       resolve;
    logic       resolve_team;

    truco_round_resolver u_resolver (
        .h0       (h0_q),
        .h1       ((hand_idx_q == 2'd1) ? hand_result : h1_q),
        .h2       (hand_result),
        .hand_idx (hand_idx_q),
        .mao_team (mao_team),
        .decided  (res_decided),
        .winner   (res_winner)
    );

`ifdef MAO_DE_ONZE_EN
    // Exactly one team one point from winning: stake fixed at 3, no raises.
    assign mao_onze = (score_a_q == WIN_M1) != (score_b_q == WIN_M1);
`else
    assign mao_onze = 1'b0;
`endif

    assign stake_raised = (truco_req && !mao_onze) ? next_stake(round_value_q) : round_value_q;
    assign hand_legal   = hand_valid && (hand_result != RES_NONE);

    always_comb begin
        state_d        = state_q;
        hand_idx_d     = hand_idx_q;
        round_value_d  = round_value_q;
        h0_d           = h0_q;
        h1_d           = h1_q;
        round_done_d   = 1'b0;
        round_winner_d = round_winner_q;
        score_a_d      = score_a_q;
        score_b_d      = score_b_q;
        game_over_d    = game_over_q;
        game_winner_d  = game_winner_q;
        resolve        = 1'b0;
        resolve_team   = TEAM_A;

        if (new_game) begin
            state_d       = ST_PLAY;
            hand_idx_d    = 2'd0;
            round_value_d = STAKE_1;
            h0_d          = RES_NONE;
            h1_d          = RES_NONE;
            score_a_d     = '0;
            score_b_d     = '0;
            game_over_d   = 1'b0;
            game_winner_d = 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    round_value_d = stake_raised;
                    if (fold_valid) begin
                        resolve      = 1'b1;
                        resolve_team = ~fold_team;
                    end else if (hand_legal) begin
                        if (hand_idx_q == 2'd0) begin
                            h0_d       = hand_result;
                            hand_idx_d = 2'd1;
                        end else if (res_decided) begin
                            resolve      = 1'b1;
                            resolve_team = res_winner;
                        end else begin
                            h1_d       = hand_result;
                            hand_idx_d = 2'd2;
                        end
                    end
                end
                ST_ROUND_END: begin
                    if (score_a_q == WIN || score_b_q == WIN) begin
                        state_d       = ST_GAME_OVER;
                        game_over_d   = 1'b1;
                        game_winner_d = (score_b_q == WIN) ? TEAM_B : TEAM_A;
                    end else begin
                        state_d       = ST_PLAY;
                        hand_idx_d    = 2'd0;
                        round_value_d = mao_onze ? STAKE_3 : STAKE_1;
                        h0_d          = RES_NONE;
                        h1_d          = RES_NONE;
                    end
                end
                default: ;
            endcase
        end

        if (resolve) begin
            state_d        = ST_ROUND_END;
            round_done_d   = 1'b1;
            round_winner_d = resolve_team;
            if (resolve_team == TEAM_B) score_b_d = sat_add(score_b_q, stake_raised);
            else                        score_a_d = sat_add(score_a_q, stake_raised);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q        <= ST_PLAY;
            hand_idx_q     <= 2'd0;
            round_value_q  <= STAKE_1;
            h0_q           <= RES_NONE;
            h1_q           <= RES_NONE;
            round_done_q   <= 1'b0;
            round_winner_q <= 1'b0;
            score_a_q      <= '0;
            score_b_q      <= '0;
            game_over_q    <= 1'b0;
            game_winner_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hand_idx_q     <= hand_idx_d;
            round_value_q  <= round_value_d;
            h0_q           <= h0_d;
            h1_q           <= h1_d;
            round_done_q   <= round_done_d;
            round_winner_q <= round_winner_d;
            score_a_q      <= score_a_d;
            score_b_q      <= score_b_d;
            game_over_q    <= game_over_d;
            game_winner_q  <= game_winner_d;
        end
    end

    assign hand_idx     = hand_idx_q;
    assign round_value  = round_value_q;
    assign round_done   = round_done_q;
    assign round_winner = round_winner_q;
    assign score_a      = score_a_q;
    assign score_b      = score_b_q;
    assign game_over    = game_over_q;
    assign game_winner  = game_winner_q;

endmodule

// File: tb/tb_truco_round_tracker.sv
// Directed self-checking bench for truco_round_tracker (default parameters).
module tb_truco_round_tracker;

    logic       clk, clr, new_game, hand_valid, mao_team, truco_req, fold_valid, fold_team;
    logic [1:0] hand_result;
    logic [1:0] hand_idx;
    logic [3:0] round_value;
    logic       round_done, round_winner, game_over, game_winner;
    logic [4:0] score_a, score_b;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] HA = 2'b01, HB = 2'b10, HT = 2'b11, HX = 2'b00;

    truco_round_tracker dut (
        .clk(clk), .clr(clr), .new_game(new_game), .hand_valid(hand_valid),
        .hand_result(hand_result), .mao_team(mao_team), .truco_req(truco_req),
        .fold_valid(fold_valid), .fold_team(fold_team), .hand_idx(hand_idx),
        .round_value(round_value), .round_done(round_done), .round_winner(round_winner),
        .score_a(score_a), .score_b(score_b), .game_over(game_over), .game_winner(game_winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic play_hand(input logic [1:0] r);
        hand_valid = 1'b1; hand_result = r;
        cyc();
        hand_valid = 1'b0; hand_result = HX;
    endtask

    task automatic raise();
        truco_req = 1'b1;
        cyc();
        truco_req = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
    endtask

    // Raise n times, win two straight hands with r, then step out of ROUND_END.
    task automatic play_round(input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) raise();
        play_hand(r);
        play_hand(r);
        cyc();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        cyc();
        if (hand_idx !== 2'd0 || round_value !== 4'd1 || round_done !== 1'b0 || round_winner !== 1'b0) begin
            failures++;
            $display("FAIL reset_round got idx=%0d val=%0d done=%0d win=%0d exp 0 1 0 0",
                     hand_idx, round_value, round_done, round_winner);
        end
        checks++;
        if (score_a !== 5'd0 || score_b !== 5'd0 || game_over !== 1'b0 || game_winner !== 1'b0) begin
            failures++;
            $display("FAIL reset_score got a=%0d b=%0d go=%0d gw=%0d exp 0 0 0 0",
                     score_a, score_b, game_over, game_winner);
        end
        checks++;
        clr = 1'b0;
        cyc();
    endtask

    task automatic test_basic_round();
        play_hand(HA);
        if (hand_idx !== 2'd1 || round_done !== 1'b0) begin
            failures++;
            $display("FAIL hand0_store got idx=%0d done=%0d exp 1 0", hand_idx, round_done);
        end
        checks++;
        play_hand(HA);
        if (round_done !== 1'b1 || round_winner !== 1'b0 || score_a !== 5'd1 || score_b !== 5'd0) begin
            failures++;
            $display("FAIL aa_resolve got done=%0d win=%0d a=%0d b=%0d exp 1 0 1 0",
                     round_done, round_winner, score_a, score_b);
        end
        checks++;
        cyc();
        if (round_done !== 1'b0 || hand_idx !== 2'd0 || round_value !== 4'd1 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL aa_next_round got done=%0d idx=%0d val=%0d go=%0d exp 0 0 1 0",
                     round_done, hand_idx, round_value, game_over);
        end
        checks++;
    endtask

    task automatic test_tie_rules();
        play_hand(HT);
        play_hand(HB);
        if (round_done !== 1'b1 || round_winner !== 1'b1 || score_b !== 5'd1) begin
            failures++;
            $display("FAIL tie_then_b got done=%0d win=%0d b=%0d exp 1 1 1", round_done, round_winner, score_b);
        end
        checks++;
        cyc();
        play_hand(HA);
        play_hand(HB);
        if (hand_idx !== 2'd2 || round_done !== 1'b0) begin
            failures++;
            $display("FAIL split_continue got idx=%0d done=%0d exp 2 0", hand_idx, round_done);
        end
        checks++;
        play_hand(HT);
        if (round_done !== 1'b1 || round_winner !== 1'b0 || score_a !== 5'd2) begin
            failures++;
            $display("FAIL first_hand_rule got done=%0d win=%0d a=%0d exp 1 0 2", round_done, round_winner, score_a);
        end
        checks++;
        cyc();
        mao_team = 1'b1;
        play_hand(HT);
        play_hand(HT);
        if (hand_idx !== 2'd2) begin
            failures++;
            $display("FAIL double_tie_continue got idx=%0d exp 2", hand_idx);
        end
        checks++;
        play_hand(HT);
        if (round_done !== 1'b1 || round_winner !== 1'b1 || score_b !== 5'd2 || score_a !== 5'd2) begin
            failures++;
            $display("FAIL mao_breaks_tie got done=%0d win=%0d a=%0d b=%0d exp 1 1 2 2",
                     round_done, round_winner, score_a, score_b);
        end
        checks++;
        mao_team = 1'b0;
        cyc();
        play_hand(HX);
        if (hand_idx !== 2'd0 || round_done !== 1'b0 || score_a !== 5'd2 || score_b !== 5'd2) begin
            failures++;
            $display("FAIL illegal_ignored got idx=%0d done=%0d a=%0d b=%0d exp 0 0 2 2",
                     hand_idx, round_done, score_a, score_b);
        end
        checks++;
    endtask

    task automatic test_truco_cap();
        int exp_v[5];
        exp_v = '{3, 6, 9, 12, 12};
        pulse_new_game();
        if (score_a !== 5'd0 || score_b !== 5'd0 || round_value !== 4'd1) begin
            failures++;
            $display("FAIL new_game_clear got a=%0d b=%0d val=%0d exp 0 0 1", score_a, score_b, round_value);
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            raise();
            if (round_value !== 4'(exp_v[i])) begin
                failures++;
                $display("FAIL ladder_%0d got val=%0d exp %0d", i, round_value, exp_v[i]);
            end
            checks++;
        end
        play_hand(HB);
        play_hand(HB);
        if (round_done !== 1'b1 || round_winner !== 1'b1 || score_b !== 5'd12 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL stake12_resolve got done=%0d win=%0d b=%0d go=%0d exp 1 1 12 0",
                     round_done, round_winner, score_b, game_over);
        end
        checks++;
        cyc();
        if (game_over !== 1'b1 || game_winner !== 1'b1 || round_done !== 1'b0) begin
            failures++;
            $display("FAIL game_over_b got go=%0d gw=%0d done=%0d exp 1 1 0", game_over, game_winner, round_done);
        end
        checks++;
        hand_valid = 1'b1; hand_result = HA; truco_req = 1'b1;
        cyc(); cyc();
        hand_valid = 1'b0; hand_result = HX; truco_req = 1'b0;
        if (score_a !== 5'd0 || score_b !== 5'd12 || round_done !== 1'b0 || game_over !== 1'b1 || round_value !== 4'd12) begin
            failures++;
            $display("FAIL game_over_hold got a=%0d b=%0d done=%0d go=%0d val=%0d exp 0 12 0 1 12",
                     score_a, score_b, round_done, game_over, round_value);
        end
        checks++;
    endtask

    task automatic test_fold_saturate();
        pulse_new_game();
        play_round(HA, 3);
        play_round(HA, 0);
        if (score_a !== 5'd10 || round_value !== 4'd1) begin
            failures++;
            $display("FAIL setup_a10 got a=%0d val=%0d exp 10 1", score_a, round_value);
        end
        checks++;
        truco_req = 1'b1; fold_valid = 1'b1; fold_team = 1'b1; hand_valid = 1'b1; hand_result = HB;
        cyc();
        truco_req = 1'b0; fold_valid = 1'b0; fold_team = 1'b0; hand_valid = 1'b0; hand_result = HX;
        if (round_done !== 1'b1 || round_winner !== 1'b0 || score_a !== 5'd12 || score_b !== 5'd0
            || hand_idx !== 2'd0 || round_value !== 4'd3) begin
            failures++;
            $display("FAIL fold_sat got done=%0d win=%0d a=%0d b=%0d idx=%0d val=%0d exp 1 0 12 0 0 3",
                     round_done, round_winner, score_a, score_b, hand_idx, round_value);
        end
        checks++;
        cyc();
        if (game_over !== 1'b1 || game_winner !== 1'b0) begin
            failures++;
            $display("FAIL fold_game_over got go=%0d gw=%0d exp 1 0", game_over, game_winner);
        end
        checks++;
    endtask

    task automatic test_async_clear();
        pulse_new_game();
        if (score_a !== 5'd0 || game_over !== 1'b0 || game_winner !== 1'b0) begin
            failures++;
            $display("FAIL new_game_from_over got a=%0d go=%0d gw=%0d exp 0 0 0", score_a, game_over, game_winner);
        end
        checks++;
        play_round(HA, 0);
        play_hand(HA);
        play_hand(HB);
        raise();
        raise();
        if (hand_idx !== 2'd2 || round_value !== 4'd6 || score_a !== 5'd1) begin
            failures++;
            $display("FAIL mid_round_setup got idx=%0d val=%0d a=%0d exp 2 6 1", hand_idx, round_value, score_a);
        end
        checks++;
        #2 clr = 1'b1;
        #1;
        if (hand_idx !== 2'd0 || round_value !== 4'd1 || score_a !== 5'd0 || round_done !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL async_clr got idx=%0d val=%0d a=%0d done=%0d go=%0d exp 0 1 0 0 0",
                     hand_idx, round_value, score_a, round_done, game_over);
        end
        checks++;
        cyc();
        clr = 1'b0;
        cyc();
    endtask

    task automatic test_mao_de_onze();
        logic [3:0] exp_val;
        play_round(HB, 1);
        play_round(HB, 0);
        play_round(HB, 0);
        play_round(HA, 3);
        play_round(HA, 0);
        play_round(HA, 0);
`ifdef MAO_DE_ONZE_EN
        exp_val = 4'd3;
`else
        exp_val = 4'd1;
`endif
        if (score_a !== 5'd11 || score_b !== 5'd5 || round_value !== exp_val) begin
            failures++;
            $display("FAIL onze_start got a=%0d b=%0d val=%0d exp 11 5 %0d", score_a, score_b, round_value, exp_val);
        end
        checks++;
        raise();
        raise();
`ifdef MAO_DE_ONZE_EN
        exp_val = 4'd3;
`else
        exp_val = 4'd6;
`endif
        if (round_value !== exp_val) begin
            failures++;
            $display("FAIL onze_truco got val=%0d exp %0d", round_value, exp_val);
        end
        checks++;
        play_hand(HA);
        play_hand(HA);
        cyc();
        if (score_a !== 5'd12 || game_over !== 1'b1 || game_winner !== 1'b0) begin
            failures++;
            $display("FAIL onze_win got a=%0d go=%0d gw=%0d exp 12 1 0", score_a, game_over, game_winner);
        end
        checks++;
    endtask

    initial begin
        clr = 1'b1; new_game = 1'b0; hand_valid = 1'b0; hand_result = HX;
        mao_team = 1'b0; truco_req = 1'b0; fold_valid = 1'b0; fold_team = 1'b0;
        test_reset();
        test_basic_round();
        test_tie_rules();
        test_truco_cap();
        test_fold_saturate();
        test_async_clear();
        test_mao_de_onze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/truco_round_tracker.md
Name: truco_round_tracker

Overview:
Sequential scorekeeper for the Truco table. It consumes per-hand results from the card-compare stage and resolves the best-of-3 round winner. It tracks the round stake (truco ladder), accumulates team scores and flags game end. Its registered outputs drive the flip-flop-based score/LED display stage directly downstream.

Parameters:
WIN_SCORE, 12, points that end the game.
SCORE_W, 5, score register width; must hold WIN_SCORE.

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, asynchronous, active-high
new_game  in  1  pulse; clears scores and round, enters PLAY
hand_valid  in  1  pulse; hand_result valid this cycle
hand_result  in  2  01=team A, 10=team B, 11=tie, 00=illegal (ignored)
mao_team  in  1  team holding "mão" (0=A, 1=B); breaks an all-tie round
truco_req  in  1  pulse; raise stake one ladder step
fold_valid  in  1  pulse; fold_team gives up the round
fold_team  in  1  folding team
hand_idx  out  2  current hand 0..2
round_value  out  4  current stake: 1,3,6,9,12
round_done  out  1  one-cycle pulse when a round resolves
round_winner  out  1  winner of last resolved round (held)
score_a  out  SCORE_W  team A score
score_b  out  SCORE_W  team B score
game_over  out  1  high in GAME_OVER
game_winner  out  1  valid while game_over

Behaviour:
- Reset (clr=1, async): state=PLAY, hand_idx=0, round_value=1, round_done=0, round_winner=0, scores=0, game_over=0, game_winner=0, stored hand results cleared.
- States: PLAY, ROUND_END, GAME_OVER.
- Event priority in PLAY: new_game > fold_valid > hand_valid. truco_req is applied in the same cycle as the others, and the raised stake counts for a round resolved in that cycle.
- Stake ladder: 1→3→6→9→12. truco_req at 12 is ignored.
- Hand 0: store result; hand_idx becomes 1. No decision.
- Hand 1:
  - h0=X and h1=X → X.
  - h0=tie and h1=X → X.
  - h0=X and h1=tie → X.
  - Split wins or double tie → continue; hand_idx becomes 2.
- Hand 2:
  - h2=X → X.
  - h2=tie → h0 winner if h0 was not a tie, else mao_team.
- Fold: the other team wins at the current round_value.
- Resolution at edge N. At N+1:
  - State is ROUND_END; round_done=1; round_winner is updated.
  - Winner's score += round_value, saturating at WIN_SCORE.
  - Leaving ROUND_END (edge N+2): GAME_OVER if a score equals WIN_SCORE, else PLAY with hand_idx=0 and round_value=1.
- In ROUND_END and GAME_OVER, hand_valid, truco_req and fold_valid are ignored. new_game is honoured in every state.
- GAME_OVER: game_over=1; game_winner = team with WIN_SCORE. Scores are held until new_game or clr.
- Illegal hand_result 00: no state change, hand_idx unchanged.

Optional Feature:
MAO_DE_ONZE_EN
- Defined: when exactly one team has WIN_SCORE-1 points, each new round starts with round_value=3 and truco_req is ignored for that round.
- Undefined: no special case; normal ladder always applies.

Decomposition:
- Package truco_pkg:
  - hand result codes (RES_A, RES_B, RES_TIE, RES_NONE)
  - state enum
  - stake ladder constants
  - team encoding
- One natural combinational sub-module: truco_round_resolver. Inputs are h0, h1, h2 result, hand_idx and mao_team. Outputs are decided and winner. This isolates the tie rules for unit testing.

Test Plan:
1. Hands A, A → round_done at cycle after hand 2, round_winner=0, score_a=1, hand_idx back to 0.
2. Hands tie, B → winner B. Then hands A, B, tie → winner A (first-hand rule). Then tie, tie, tie with mao_team=1 → winner B.
3. truco_req ×5, then hands B, B → round_value capped at 12, score_b=12, game_over=1, game_winner=1; further hand_valid has no effect.
4. score_a=10, truco_req then fold_valid with fold_team=1, same cycle as hand_valid → score_a=12 (saturated), hand ignored, GAME_OVER.
5. clr asserted mid-round (hand_idx=2, round_value=6) → all outputs return to reset values asynchronously. new_game in GAME_OVER → scores 0, state PLAY.
6. With MAO_DE_ONZE_EN, score_a=11 and score_b=5 → round_value=3, truco_req ignored, A wins → score_a=12.
